// File: rtl/card_dealer.sv
`default_nettype none
// ============================================================================
// card_dealer : draws unique cards from a 52-card deck via LFSR + linear probe
// Rev 1.0
// ============================================================================
module card_dealer #(
  parameter int ACE_POINTS  = 11,
  parameter int FACE_POINTS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] rnd,
  input  logic       deal_req,
  input  logic       shuffle,
  output logic       busy,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [4:0] card_points,
  output logic [5:0] cards_left,
  output logic       deck_empty
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_PROBE = 2'd2
  } state_t;

  state_t      state_q;
  logic [51:0] used_q;
  logic [5:0]  idx_q;
  logic        busy_q;
  logic        card_valid_q;
  logic [3:0]  card_rank_q;
  logic [1:0]  card_suit_q;
  logic [4:0]  card_points_q;
  logic [5:0]  cards_left_q;
  logic        deck_empty_q;

  logic [5:0]  draw_idx_d;
  logic [5:0]  probe_idx_d;
  logic [5:0]  suit_base_d;
  logic [1:0]  suit_d;
  logic [3:0]  rank_d;
  logic [4:0]  points_d;

  // Suit/rank from the probed index by comparator chain rather than a divider
  always_comb begin
    suit_d      = 2'd0;
    suit_base_d = 6'd0;
    if (idx_q >= 6'd39) begin
      suit_d      = 2'd3;
      suit_base_d = 6'd39;
    end else if (idx_q >= 6'd26) begin
      suit_d      = 2'd2;
      suit_base_d = 6'd26;
    end else if (idx_q >= 6'd13) begin
      suit_d      = 2'd1;
      suit_base_d = 6'd13;
    end
    rank_d = 4'(idx_q - suit_base_d) + 4'd1;

    if (rank_d == 4'd1)
      points_d = 5'(ACE_POINTS);
    else if (rank_d >= 4'd11)
      points_d = 5'(FACE_POINTS);
    else
      points_d = {1'b0, rank_d};

    draw_idx_d  = (rnd < 6'd52) ? rnd : (rnd - 6'd52);
    probe_idx_d = (idx_q == 6'd51) ? 6'd0 : (idx_q + 6'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      used_q        <= '0;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      card_valid_q  <= 1'b0;
      card_rank_q   <= '0;
      card_suit_q   <= '0;
      card_points_q <= '0;
      cards_left_q  <= 6'd52;
      deck_empty_q  <= 1'b0;
    end else begin
      card_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (shuffle) begin
            used_q       <= '0;
            cards_left_q <= 6'd52;
            deck_empty_q <= 1'b0;
          end else if (deal_req && !deck_empty_q) begin
            state_q <= S_DRAW;
            busy_q  <= 1'b1;
          end
        end
        S_DRAW: begin
          idx_q   <= draw_idx_d;
          state_q <= S_PROBE;
        end
        S_PROBE: begin
          // Terminates because a draw only starts with at least one free card
          if (used_q[idx_q]) begin
            idx_q <= probe_idx_d;
          end else begin
            used_q[idx_q] <= 1'b1;
            cards_left_q  <= cards_left_q - 6'd1;
            deck_empty_q  <= (cards_left_q == 6'd1);
            card_rank_q   <= rank_d;
            card_suit_q   <= suit_d;
            card_points_q <= points_d;
            card_valid_q  <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign card_valid  = card_valid_q;
  assign card_rank   = card_rank_q;
  assign card_suit   = card_suit_q;
  assign card_points = card_points_q;
  assign cards_left  = cards_left_q;
  assign deck_empty  = deck_empty_q;

endmodule
`default_nettype wire

// File: tb/tb_card_dealer.sv
`default_nettype none
// ============================================================================
// tb_card_dealer : directed self-checking bench for card_dealer
// Rev 1.0
// ============================================================================
module tb_card_dealer;

  logic       clk;
  logic       reset;
  logic [5:0] rnd;
  logic       deal_req;
  logic       shuffle;
  logic       busy;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [4:0] card_points;
  logic [5:0] cards_left;
  logic       deck_empty;

  int n_checks = 0;
  int n_errors = 0;

  card_dealer #(.ACE_POINTS(11), .FACE_POINTS(10)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .rnd         (rnd),
    .deal_req    (deal_req),
    .shuffle     (shuffle),
    .busy        (busy),
    .card_valid  (card_valid),
    .card_rank   (card_rank),
    .card_suit   (card_suit),
    .card_points (card_points),
    .cards_left  (cards_left),
    .deck_empty  (deck_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One deal; lat counts edges from the one that samples deal_req up to card_valid
  task automatic deal(input logic [5:0] r, input int lat, input int rank,
                      input int suit, input int pts, input int left);
    int edges;
    @(negedge clk);
    rnd      = r;
    deal_req = 1'b1;
    @(posedge clk); #1;
    deal_req = 1'b0;
    edges    = 1;
    check("busy_draw", int'(busy), 1);
    while (!card_valid && edges < 80) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, lat);
    check("busy_valid", int'(busy), 0);
    check("rank", int'(card_rank), rank);
    check("suit", int'(card_suit), suit);
    check("points", int'(card_points), pts);
    check("cards_left", int'(cards_left), left);
    check("deck_empty", int'(deck_empty), (left == 0) ? 1 : 0);
  endtask

  task automatic no_pulse(input string tag, input int cycles);
    int seen_valid = 0;
    int seen_busy  = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (card_valid) seen_valid++;
      if (busy) seen_busy++;
    end
    check({tag, "_valid"}, seen_valid, 0);
    check({tag, "_busy"}, seen_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, s, p;
    reset    = 1'b1;
    rnd      = 6'd0;
    deal_req = 1'b0;
    shuffle  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(card_valid), 0);
    check("rst_rank", int'(card_rank), 0);
    check("rst_suit", int'(card_suit), 0);
    check("rst_points", int'(card_points), 0);
    check("rst_left", int'(cards_left), 52);
    check("rst_empty", int'(deck_empty), 0);
    @(negedge clk);
    reset = 1'b0;

    deal(6'd5, 3, 6, 0, 6, 51);
    deal(6'd5, 4, 7, 0, 7, 50);
    deal(6'd60, 3, 9, 0, 9, 49);
    deal(6'd51, 3, 13, 3, 10, 48);
    deal(6'd51, 4, 1, 0, 11, 47);
    deal(6'd23, 3, 11, 1, 10, 46);
    deal(6'd38, 3, 13, 2, 10, 45);

    // Fields hold after the pulse
    no_pulse("idle_hold", 3);
    check("hold_rank", int'(card_rank), 13);
    check("hold_suit", int'(card_suit), 2);

    // Shuffle wins over a simultaneous deal request
    @(negedge clk);
    shuffle  = 1'b1;
    deal_req = 1'b1;
    @(posedge clk); #1;
    shuffle  = 1'b0;
    deal_req = 1'b0;
    check("shuf_left", int'(cards_left), 52);
    check("shuf_busy", int'(busy), 0);
    no_pulse("shuf_drop", 4);
    check("shuf_rank_hold", int'(card_rank), 13);

    // Drain the whole deck with rnd stuck at 0: k-th deal lands on idx k
    for (int k = 0; k < 52; k++) begin
      r = (k % 13) + 1;
      s = k / 13;
      p = (r == 1) ? 11 : ((r >= 11) ? 10 : r);
      deal(6'd0, 3 + k, r, s, p, 51 - k);
    end
    check("empty_left", int'(cards_left), 0);
    check("empty_flag", int'(deck_empty), 1);

    @(negedge clk);
    deal_req = 1'b1;
    @(posedge clk); #1;
    deal_req = 1'b0;
    check("empty_req_busy", int'(busy), 0);
    no_pulse("empty_req", 6);
    check("empty_still", int'(deck_empty), 1);

    @(negedge clk);
    shuffle = 1'b1;
    @(posedge clk); #1;
    shuffle = 1'b0;
    check("reshuf_left", int'(cards_left), 52);
    check("reshuf_empty", int'(deck_empty), 0);

    // Reset during PROBE aborts the draw and leaves the card unused
    deal(6'd0, 3, 1, 0, 11, 51);
    @(negedge clk);
    rnd      = 6'd5;
    deal_req = 1'b1;
    @(posedge clk); #1;
    deal_req = 1'b0;
    @(posedge clk); #1;
    check("probe_busy", int'(busy), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", int'(card_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_left", int'(cards_left), 52);
    check("abort_rank", int'(card_rank), 0);
    @(negedge clk);
    reset = 1'b0;
    deal(6'd0, 3, 1, 0, 11, 51);
    deal(6'd5, 3, 6, 0, 6, 50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
